// File: rtl/ddc_pri_ctrl.sv
// rtl/ddc_pri_ctrl.sv - per-PRI DDC sequencer: range delay, mixer phase reset, sample window, output flags
// Outputs are flops fed from next-state decode so cycle numbers are output-visible.
module ddc_pri_ctrl #(
  parameter int MIX_LAT = 3,
  parameter int RST_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pri,
  input  logic [CNT_W-1:0] i_cfg_delay,
  input  logic [CNT_W-1:0] i_cfg_len,
  input  logic             i_cfg_load,
  input  logic             i_err_clr,
  output logic             o_mix_rst,
  output logic             o_win_open,
  output logic             o_dout_valid,
  output logic             o_dout_sof,
  output logic             o_dout_eof,
  output logic             o_busy,
  output logic [15:0]      o_pri_cnt,
  output logic             o_ovr_err
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PHRST, S_WINDOW} state_t;

  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [CNT_W-1:0]   r_sh_delay, r_sh_len, r_act_len;
  logic               r_pri_d;
  logic               w_edge, w_accept, w_win_n, w_last_n;
  logic               r_mix_rst, r_busy, r_win, r_wsof, r_weof, r_ovr;
  logic [15:0]        r_pri_cnt;
  logic [MIX_LAT-1:0] r_vp, r_sp, r_ep;

  assign w_edge   = i_pri & ~r_pri_d;
  assign w_accept = w_edge & (r_state == S_IDLE);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // The accepting PRI reads the shadow directly; active length is captured alongside.
        if (w_accept) begin
          if (r_sh_delay != '0) begin
            w_state_n = S_DELAY;
            w_cnt_n   = r_sh_delay - ONE;
          end else if (r_sh_len != '0) begin
            w_state_n = S_PHRST;
            w_cnt_n   = RST_LD;
          end
        end
      end
      S_DELAY: begin
        if (r_cnt == '0) begin
          w_state_n = S_PHRST;
          w_cnt_n   = RST_LD;
        end else begin
          w_cnt_n = r_cnt - ONE;
        end
      end
      S_PHRST: begin
        if (r_cnt == '0) begin
          if (r_act_len != '0) begin
            w_state_n = S_WINDOW;
            w_cnt_n   = r_act_len - ONE;
          end else begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
          end
        end else begin
          w_cnt_n = r_cnt - ONE;
        end
      end
      S_WINDOW: begin
        if (r_cnt == '0) begin
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - ONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  assign w_win_n  = (w_state_n == S_WINDOW);
  assign w_last_n = w_win_n & (w_cnt_n == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sh_delay <= '0;
      r_sh_len   <= '0;
      r_act_len  <= '0;
      r_pri_d    <= 1'b0;
      r_mix_rst  <= 1'b1;
      r_busy     <= 1'b0;
      r_win      <= 1'b0;
      r_wsof     <= 1'b0;
      r_weof     <= 1'b0;
      r_ovr      <= 1'b0;
      r_pri_cnt  <= '0;
      r_vp       <= '0;
      r_sp       <= '0;
      r_ep       <= '0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_pri_d   <= i_pri;
      r_mix_rst <= (w_state_n == S_PHRST);
      r_busy    <= (w_state_n != S_IDLE);
      r_win     <= w_win_n;
      // SOF/EOF travel as their own bits so overlapping tails cannot merge flags.
      r_wsof    <= w_win_n & ~r_win;
      r_weof    <= w_last_n;
      if (i_cfg_load) begin
        r_sh_delay <= i_cfg_delay;
        r_sh_len   <= i_cfg_len;
      end
      if (w_accept) begin
        r_act_len <= r_sh_len;
        r_pri_cnt <= r_pri_cnt + 16'd1;
      end
      if (w_edge && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end else if (i_err_clr) begin
        r_ovr <= 1'b0;
      end
      r_vp[0] <= r_win;
      r_sp[0] <= r_wsof;
      r_ep[0] <= r_weof;
      for (int k = 1; k < MIX_LAT; k++) begin
        r_vp[k] <= r_vp[k-1];
        r_sp[k] <= r_sp[k-1];
        r_ep[k] <= r_ep[k-1];
      end
    end
  end

  assign o_mix_rst    = r_mix_rst;
  assign o_win_open   = r_win;
  assign o_dout_valid = r_vp[MIX_LAT-1];
  assign o_dout_sof   = r_sp[MIX_LAT-1];
  assign o_dout_eof   = r_ep[MIX_LAT-1];
  assign o_busy       = r_busy;
  assign o_pri_cnt    = r_pri_cnt;
  assign o_ovr_err    = r_ovr;

endmodule
